// File: rtl/tx_frame_loader_pkg.sv
// Shared definitions for the TX frame loader.
// Contents: TX event codes, loader state encoding, error codes and length check.
package tx_frame_loader_pkg;

  localparam logic [2:0] TX_EVENT_STARTED  = 3'd1;
  localparam logic [2:0] TX_EVENT_PREAMBLE = 3'd2;
  localparam logic [2:0] TX_EVENT_SFD      = 3'd3;
  localparam logic [2:0] TX_EVENT_PHR      = 3'd4;
  localparam logic [2:0] TX_EVENT_BYTE     = 3'd5;
  localparam logic [2:0] TX_EVENT_END      = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_ABORT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_LEN = 2'd1,
    ERR_COUNT   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  function automatic logic len_ok(input logic [7:0] b, input int unsigned max_len);
    return (b != 8'd0) && (32'(b) <= max_len);
  endfunction

endpackage

// File: rtl/tx_frame_loader.sv
// Loads a host frame (PHR + payload) into the TX buffer, starts the transmitter
// and supervises it through its event stream with a watchdog.
module tx_frame_loader
  import tx_frame_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned MAX_LEN = 127
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic [6:0] o_buf_w_addr,
  output logic       o_buf_w_en,
  output logic [7:0] o_buf_byte,
  output logic       o_start,
  input  logic [2:0] i_tx_ev,
  input  logic       i_tx_ev_sig,
  output logic       o_tx_abort,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  localparam int unsigned     WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  state_e          r_state, w_state_nxt;
  logic [6:0]      r_len, w_len_nxt;
  logic [6:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [6:0]      r_ev_cnt, w_ev_cnt_nxt;
  logic [WD_W-1:0] r_wd, w_wd_nxt, w_wd_inc;
  logic            r_ready, w_ready_nxt;
  logic [6:0]      r_addr, w_addr_nxt;
  logic            r_w_en, w_w_en_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic            r_start, w_start_nxt;
  logic            r_abort, w_abort_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  err_code_e       r_code, w_code_nxt;
  logic            w_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_ev_cnt <= '0;
      r_wd     <= '0;
      r_ready  <= 1'b0;
      r_addr   <= '0;
      r_w_en   <= 1'b0;
      r_data   <= '0;
      r_start  <= 1'b0;
      r_abort  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= ERR_NONE;
    end else begin
      r_state  <= w_state_nxt;
      r_len    <= w_len_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ev_cnt <= w_ev_cnt_nxt;
      r_wd     <= w_wd_nxt;
      r_ready  <= w_ready_nxt;
      r_addr   <= w_addr_nxt;
      r_w_en   <= w_w_en_nxt;
      r_data   <= w_data_nxt;
      r_start  <= w_start_nxt;
      r_abort  <= w_abort_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_code   <= w_code_nxt;
    end
  end

  always_comb begin
    w_hs         = r_ready & i_byte_valid;
    w_cnt_inc    = r_cnt + 7'd1;
    w_wd_inc     = (r_wd == '1) ? r_wd : r_wd + 1'b1;
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_cnt_nxt    = r_cnt;
    w_ev_cnt_nxt = r_ev_cnt;
    w_wd_nxt     = r_wd;
    w_addr_nxt   = r_addr;
    w_w_en_nxt   = 1'b0;
    w_data_nxt   = r_data;
    w_start_nxt  = 1'b0;
    w_abort_nxt  = 1'b0;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_code_nxt   = r_code;

    unique case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          if (len_ok(i_byte, MAX_LEN)) begin
            w_w_en_nxt  = 1'b1;
            w_addr_nxt  = '0;
            w_data_nxt  = i_byte;
            w_len_nxt   = i_byte[6:0];
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_err_nxt  = 1'b1;
            w_code_nxt = ERR_BAD_LEN;
          end
        end
      end
      ST_LOAD: begin
        if (w_hs) begin
          w_w_en_nxt = 1'b1;
          w_addr_nxt = w_cnt_inc;
          w_data_nxt = i_byte;
          w_cnt_nxt  = w_cnt_inc;
          if (w_cnt_inc == r_len) w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_start_nxt  = 1'b1;
        w_ev_cnt_nxt = '0;
        w_wd_nxt     = '0;
        w_state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        // The event cycle itself counts as the first watchdog cycle, so expiry
        // lands exactly TIMEOUT cycles after the last event; an event beats expiry.
        if (i_tx_ev_sig) begin
          w_wd_nxt = WD_W'(1);
          if (i_tx_ev == TX_EVENT_BYTE) w_ev_cnt_nxt = r_ev_cnt + 7'd1;
          if (i_tx_ev == TX_EVENT_END) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
            if (r_ev_cnt == r_len) begin
              w_done_nxt = 1'b1;
            end else begin
              w_err_nxt  = 1'b1;
              w_code_nxt = ERR_COUNT;
            end
          end
        end else begin
          w_wd_nxt = w_wd_inc;
          if (w_wd_inc >= WD_LIMIT) begin
            w_abort_nxt = 1'b1;
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_TIMEOUT;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_ABORT;
          end
        end
      end
      ST_ABORT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Ready is registered from the next state so it drops on the same edge
    // that registers the final payload write.
    w_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
  end

  assign o_byte_ready = r_ready;
  assign o_buf_w_addr = r_addr;
  assign o_buf_w_en   = r_w_en;
  assign o_buf_byte   = r_data;
  assign o_start      = r_start;
  assign o_tx_abort   = r_abort;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_err_code   = r_code;

endmodule

// File: tb/tb_tx_frame_loader.sv
// Randomized scoreboard bench for tx_frame_loader: drivers push expected buffer
// writes, start pulses and completion events; a monitor pops and compares them.
module tb_tx_frame_loader;
  import tx_frame_loader_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic       o_byte_ready;
  logic [6:0] o_buf_w_addr;
  logic       o_buf_w_en;
  logic [7:0] o_buf_byte;
  logic       o_start;
  logic [2:0] i_tx_ev;
  logic       i_tx_ev_sig;
  logic       o_tx_abort;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [1:0] o_err_code;

  tx_frame_loader #(.TIMEOUT(TO), .MAX_LEN(127)) dut (
    .clk(clk), .reset(reset),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .o_buf_w_addr(o_buf_w_addr), .o_buf_w_en(o_buf_w_en), .o_buf_byte(o_buf_byte),
    .o_start(o_start), .i_tx_ev(i_tx_ev), .i_tx_ev_sig(i_tx_ev_sig),
    .o_tx_abort(o_tx_abort), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [6:0] addr; logic [7:0] data; int cyc; } wr_exp_t;
  typedef struct { logic [4:0] v; int cyc; } ev_exp_t;   // v = {done, err, abort, code}

  wr_exp_t wq[$];
  int      sq[$];
  ev_exp_t eq[$];
  logic [1:0] last_code = 2'd0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected output %0h, nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: every visible output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (o_buf_w_en) begin
      if (wq.size() == 0) unexpected("wr", {17'd0, o_buf_w_addr, o_buf_byte});
      else begin
        wr_exp_t w;
        w = wq.pop_front();
        check("wr_addr", 32'(o_buf_w_addr), 32'(w.addr));
        check("wr_data", 32'(o_buf_byte), 32'(w.data));
        check("wr_cycle", cyc, w.cyc);
      end
    end
    if (o_start) begin
      if (sq.size() == 0) unexpected("start", 32'd1);
      else check("start_cycle", cyc, sq.pop_front());
    end
    if (o_done || o_err || o_tx_abort) begin
      if (eq.size() == 0) unexpected("outcome", {o_done, o_err, o_tx_abort, o_err_code});
      else begin
        ev_exp_t e;
        e = eq.pop_front();
        check("outcome", 32'({o_done, o_err, o_tx_abort, o_err_code}), 32'(e.v));
        check("outcome_cycle", cyc, e.cyc);
      end
    end
  end

  // Offer one byte and hold it until accepted; the expectation is queued
  // before the accepting edge. Returns at the negedge after the handshake.
  task automatic send_byte(input logic [7:0] b, input bit bad, input logic [6:0] addr,
                           output int hs);
    int g = 0;
    i_byte = b;
    i_byte_valid = 1'b1;
    while (!o_byte_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      check("byte_accept_timeout", 32'd0, 32'd1);
      hs = cyc;
      i_byte_valid = 1'b0;
      return;
    end
    hs = cyc;
    if (bad) begin
      last_code = 2'd1;
      eq.push_back('{5'b01001, hs + 1});
    end else begin
      wq.push_back('{addr, b, hs + 1});
    end
    @(negedge clk);
  endtask

  task automatic send_len(input int len);
    int h;
    send_byte(8'(len), 1'b0, 7'd0, h);
    check("busy_after_len", 32'(o_busy), 32'd1);
  endtask

  task automatic load_payload(input int len, input bit stall, input bit directed,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              output int last);
    int h = 0;
    int prev = 0;
    logic [7:0] b;
    for (int i = 1; i <= len; i++) begin
      b = 8'($urandom);
      if (directed) b = (i == 1) ? d0 : (i == 2) ? d1 : d2;
      send_byte(b, 1'b0, 7'(i), h);
      if (!stall && i > 1) check("back_to_back", h, prev + 1);
      prev = h;
      if (stall && i < len && $urandom_range(0, 2) == 0) begin
        i_byte_valid = 1'b0;
        i_byte = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    last = h;
    i_byte_valid = 1'b0;
    sq.push_back(h + 2);
    @(negedge clk);
  endtask

  task automatic send_ev(input logic [2:0] code, input int gap, input bit push,
                         input logic [4:0] v, input int off, output int m);
    repeat (gap) @(negedge clk);
    i_tx_ev = code;
    i_tx_ev_sig = 1'b1;
    m = cyc;
    if (push) eq.push_back('{v, m + off});
    @(negedge clk);
    i_tx_ev_sig = 1'b0;
    i_tx_ev = 3'($urandom);
  endtask

  // Reference rule: done iff the number of BYTE events equals L, else code 2;
  // silence of TO cycles after the last event aborts with code 3.
  task automatic tx_events(input int len, input int nbytes, input bit timeout_mode,
                           output int end_cyc);
    int m;
    logic [4:0] v;
    if (timeout_mode) begin
      last_code = 2'd3;
      send_ev(TX_EVENT_STARTED, $urandom_range(0, 3), 1'b1, 5'b01111, TO, m);
      end_cyc = m;
      repeat (TO + 2) @(negedge clk);
      check("busy_after_abort", 32'(o_busy), 32'd0);
      check("code_held", 32'(o_err_code), 32'd3);
      return;
    end
    send_ev(TX_EVENT_STARTED,  $urandom_range(0, 3), 1'b0, 5'd0, 0, m);
    send_ev(TX_EVENT_PREAMBLE, $urandom_range(0, 4), 1'b0, 5'd0, 0, m);
    send_ev(TX_EVENT_SFD,      $urandom_range(0, 4), 1'b0, 5'd0, 0, m);
    send_ev(TX_EVENT_PHR,      $urandom_range(0, 4), 1'b0, 5'd0, 0, m);
    for (int i = 0; i < nbytes; i++) send_ev(TX_EVENT_BYTE, $urandom_range(0, 2), 1'b0, 5'd0, 0, m);
    if (nbytes == len) v = {3'b100, last_code};
    else begin
      last_code = 2'd2;
      v = 5'b01010;
    end
    send_ev(TX_EVENT_END, $urandom_range(0, 4), 1'b1, v, 1, m);
    end_cyc = m;
    check("busy_after_end", 32'(o_busy), 32'd0);
  endtask

  task automatic frame(input int len, input int nbytes, input bit stall, input bit tmo);
    int last, e;
    send_len(len);
    load_payload(len, stall, 1'b0, 8'd0, 8'd0, 8'd0, last);
    tx_events(len, nbytes, tmo, e);
  endtask

  task automatic bad_len(input logic [7:0] b);
    int h;
    send_byte(b, 1'b1, 7'd0, h);
    i_byte_valid = 1'b0;
    check("ready_after_bad", 32'(o_byte_ready), 32'd1);
    check("busy_after_bad", 32'(o_busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs"}, 32'({o_byte_ready, o_buf_w_addr, o_buf_w_en, o_buf_byte, o_start,
                               o_tx_abort, o_busy, o_done, o_err, o_err_code}), 32'd0);
  endtask

  initial begin
    #(64'd3_000_000);
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int last, e1, e2, h4;
    reset = 1'b1;
    i_byte = '0;
    i_byte_valid = 1'b0;
    i_tx_ev = '0;
    i_tx_ev_sig = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(o_byte_ready), 32'd1);

    // Directed normal frame
    send_len(3);
    load_payload(3, 1'b0, 1'b1, 8'hA1, 8'hB2, 8'hC3, last);
    tx_events(3, 3, 1'b0, e1);

    // Bad lengths, including the MAX_LEN+1 boundary
    bad_len(8'd0);
    bad_len(8'd200);
    bad_len(8'd128);

    // Count mismatch, then timeout
    frame(2, 1, 1'b0, 1'b0);
    frame(4, 4, 1'b0, 1'b1);

    // Back-pressure: a 4th byte waits through the whole transmission
    send_len(3);
    load_payload(3, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, last);
    fork
      begin
        send_byte(8'd2, 1'b0, 7'd0, h4);
        load_payload(2, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, last);
      end
      tx_events(3, 3, 1'b0, e1);
    join
    check("fourth_byte_hs", h4, e1 + 1);
    tx_events(2, 2, 1'b0, e2);

    // Randomized frames
    for (int k = 0; k < 10; k++) begin
      int len, nb;
      len = $urandom_range(1, 24);
      nb = len;
      if ($urandom_range(0, 3) == 0) nb = ($urandom_range(0, 1) == 0) ? len + 1 : len - 1;
      if ($urandom_range(0, 3) == 0) bad_len(8'($urandom_range(128, 255)));
      frame(len, nb, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
    end

    // Longest frame, back-to-back
    frame(127, 127, 1'b0, 1'b0);
    frame(1, 1, 1'b1, 1'b0);

    // Mid-load reset after 2 of 5 payload bytes
    send_len(5);
    send_byte(8'h5A, 1'b0, 7'd1, last);
    send_byte(8'hA5, 1'b0, 7'd2, last);
    i_byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midload_reset");
    sq.delete();
    last_code = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    frame(1, 1, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("wq_empty", wq.size(), 0);
    check("sq_empty", sq.size(), 0);
    check("eq_empty", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
